// File: rtl/serial_word_packer_if.sv
// serial_word_packer_if: bit-serial input and word output bundle; o_parity exists only with SERIAL_WORD_PACKER_PARITY_EN
interface serial_word_packer_if #(parameter int WIDTH = 8);
  logic i_a;
  logic i_valid;
  logic i_clear;
  logic [WIDTH-1:0] o_a;
  logic o_done;
  logic [$clog2(WIDTH)-1:0] o_count;
  logic [WIDTH-1:0] o_partial;
`ifdef SERIAL_WORD_PACKER_PARITY_EN
  logic o_parity;
  modport master(output i_a, i_valid, i_clear, input o_a, o_done, o_count, o_partial, o_parity);
  modport slave(input i_a, i_valid, i_clear, output o_a, o_done, o_count, o_partial, o_parity);
`else
  modport master(output i_a, i_valid, i_clear, input o_a, o_done, o_count, o_partial);
  modport slave(input i_a, i_valid, i_clear, output o_a, o_done, o_count, o_partial);
`endif
endinterface

// File: rtl/serial_word_packer.sv
// serial_word_packer: serial-to-parallel packer with wrapping bit index and done strobe; SERIAL_WORD_PACKER_PARITY_EN adds o_parity
module serial_word_packer #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic i_clk,
  input logic i_rst,
  serial_word_packer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] next_word;
  logic [CW-1:0] cnt;
  logic [CW-1:0] idx;
  logic done;
  logic last;
  always_comb idx = MSB_FIRST ? LAST - cnt : cnt;
  always_comb last = cnt == LAST;
  always_comb begin
    next_word = acc;
    next_word[idx] = bus.i_a;
  end
  // explicit wrap at LAST keeps cnt in range for non-power-of-two WIDTH
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc <= '0;
      cnt <= '0;
      word <= '0;
      done <= 1'b0;
    end else if (bus.i_clear) begin
      acc <= '0;
      cnt <= '0;
      done <= 1'b0;
    end else if (bus.i_valid) begin
      acc <= last ? '0 : next_word;
      cnt <= last ? '0 : cnt + 1'b1;
      done <= last;
      if (last) word <= next_word;
    end else begin
      done <= 1'b0;
    end
  end
`ifdef SERIAL_WORD_PACKER_PARITY_EN
  logic parity;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) parity <= 1'b0;
    else if (!bus.i_clear && bus.i_valid && last) parity <= ^next_word;
  end
  assign bus.o_parity = parity;
`endif
  assign bus.o_a = word;
  assign bus.o_done = done;
  assign bus.o_count = cnt;
  assign bus.o_partial = acc;
endmodule

// File: tb/tb_serial_word_packer.sv
// tb_serial_word_packer: three packer instances share one serial stream; per-instance word queues are checked on o_done
module tb_serial_word_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0;
  logic valid = 1'b0;
  logic clear = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [63:0] q8[$];
  logic [63:0] q8m[$];
  logic [63:0] q5[$];
  always #5 clk = ~clk;
  serial_word_packer_if #(.WIDTH(8)) b8();
  serial_word_packer_if #(.WIDTH(8)) b8m();
  serial_word_packer_if #(.WIDTH(5)) b5();
  assign b8.i_a = a;
  assign b8.i_valid = valid;
  assign b8.i_clear = clear;
  assign b8m.i_a = a;
  assign b8m.i_valid = valid;
  assign b8m.i_clear = clear;
  assign b5.i_a = a;
  assign b5.i_valid = valid;
  assign b5.i_clear = clear;
  serial_word_packer #(.WIDTH(8), .MSB_FIRST(1'b0)) u8(.i_clk(clk), .i_rst(rst), .bus(b8.slave));
  serial_word_packer #(.WIDTH(8), .MSB_FIRST(1'b1)) u8m(.i_clk(clk), .i_rst(rst), .bus(b8m.slave));
  serial_word_packer #(.WIDTH(5), .MSB_FIRST(1'b0)) u5(.i_clk(clk), .i_rst(rst), .bus(b5.slave));
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask
  task automatic beat(input logic v, input logic x, input logic c = 1'b0);
    valid = v;
    a = x;
    clear = c;
    @(negedge clk);
    valid = 1'b0;
    clear = 1'b0;
  endtask
  always @(negedge clk) if (b8.o_done) begin
    logic [63:0] e;
    chk("w8 done expected", 64'(q8.size() != 0), 64'd1);
    if (q8.size() != 0) begin
      e = q8.pop_front();
      chk("w8 word", 64'(b8.o_a), e);
`ifdef SERIAL_WORD_PACKER_PARITY_EN
      chk("w8 parity", 64'(b8.o_parity), 64'(^e));
`endif
    end
  end
  always @(negedge clk) if (b8m.o_done) begin
    logic [63:0] e;
    chk("w8m done expected", 64'(q8m.size() != 0), 64'd1);
    if (q8m.size() != 0) begin
      e = q8m.pop_front();
      chk("w8m word", 64'(b8m.o_a), e);
`ifdef SERIAL_WORD_PACKER_PARITY_EN
      chk("w8m parity", 64'(b8m.o_parity), 64'(^e));
`endif
    end
  end
  always @(negedge clk) if (b5.o_done) begin
    logic [63:0] e;
    chk("w5 done expected", 64'(q5.size() != 0), 64'd1);
    if (q5.size() != 0) begin
      e = q5.pop_front();
      chk("w5 word", 64'(b5.o_a), e);
`ifdef SERIAL_WORD_PACKER_PARITY_EN
      chk("w5 parity", 64'(b5.o_parity), 64'(^e));
`endif
    end
  end
  initial begin
    logic [7:0] pat;
    @(negedge clk);
    @(negedge clk);
    chk("reset w8 o_a", 64'(b8.o_a), 64'h0);
    chk("reset w8 o_done", 64'(b8.o_done), 64'h0);
    chk("reset w8 o_count", 64'(b8.o_count), 64'h0);
    chk("reset w8 o_partial", 64'(b8.o_partial), 64'h0);
    chk("reset w8m o_partial", 64'(b8m.o_partial), 64'h0);
    chk("reset w5 o_a", 64'(b5.o_a), 64'h0);
`ifdef SERIAL_WORD_PACKER_PARITY_EN
    chk("reset w8 parity", 64'(b8.o_parity), 64'h0);
`endif
    rst = 1'b0;
    @(negedge clk);
    q8.push_back(64'h8D);
    q8m.push_back(64'hB1);
    q5.push_back(64'h0D);
    pat = 8'b1000_1101;
    for (int i = 0; i < 8; i++) begin
      beat(1'b1, pat[i]);
      if (i == 2) begin
        chk("w8 partial 3 beats", 64'(b8.o_partial), 64'h05);
        chk("w8m partial 3 beats", 64'(b8m.o_partial), 64'hA0);
        chk("w8 count 3 beats", 64'(b8.o_count), 64'd3);
      end
    end
    chk("w8 done after 8th", 64'(b8.o_done), 64'd1);
    chk("w8 o_a after 8th", 64'(b8.o_a), 64'h8D);
    chk("w8 count wrap", 64'(b8.o_count), 64'd0);
    chk("w8m o_a after 8th", 64'(b8m.o_a), 64'hB1);
    chk("w5 count after 8", 64'(b5.o_count), 64'd3);
    beat(1'b0, 1'b0);
    chk("w8 done one cycle", 64'(b8.o_done), 64'd0);
    beat(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 1'b1);
      repeat (5) beat(1'b0, 1'b0);
    end
    chk("gap w8 count", 64'(b8.o_count), 64'd3);
    chk("gap w8 partial", 64'(b8.o_partial), 64'h07);
    chk("gap w8m partial", 64'(b8m.o_partial), 64'hE0);
    beat(1'b1, 1'b1, 1'b1);
    chk("clear w8 count", 64'(b8.o_count), 64'd0);
    chk("clear w8 partial", 64'(b8.o_partial), 64'h0);
    chk("clear w8 o_a held", 64'(b8.o_a), 64'h8D);
    chk("clear w8m o_a held", 64'(b8m.o_a), 64'hB1);
    chk("clear w5 count", 64'(b5.o_count), 64'd0);
    q8.push_back(64'hFF);
    q8.push_back(64'h00);
    q8m.push_back(64'hFF);
    q8m.push_back(64'h00);
    q5.push_back(64'h1F);
    q5.push_back(64'h07);
    q5.push_back(64'h00);
    for (int i = 0; i < 16; i++) begin
      beat(1'b1, 1'(i < 8));
      chk("b2b w8 done timing", 64'(b8.o_done), 64'(i == 7 || i == 15));
      if (i == 7) chk("b2b w8 first word", 64'(b8.o_a), 64'hFF);
    end
    chk("b2b w8 second word", 64'(b8.o_a), 64'h00);
    beat(1'b0, 1'b0, 1'b1);
    pat = 8'b0000_1101;
    for (int i = 0; i < 4; i++) beat(1'b1, pat[i]);
    #2 rst = 1'b1;
    #1;
    chk("async rst w8 partial", 64'(b8.o_partial), 64'h0);
    chk("async rst w8 count", 64'(b8.o_count), 64'h0);
    chk("async rst w8 o_a", 64'(b8.o_a), 64'h0);
    chk("async rst w8m o_a", 64'(b8m.o_a), 64'h0);
    chk("async rst w5 o_a", 64'(b5.o_a), 64'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    q8.push_back(64'h96);
    q8m.push_back(64'h69);
    q5.push_back(64'h16);
    pat = 8'b1001_0110;
    for (int i = 0; i < 8; i++) beat(1'b1, pat[i]);
    chk("post rst w8 o_a", 64'(b8.o_a), 64'h96);
    beat(1'b0, 1'b0, 1'b1);
    repeat (3) q5.push_back(64'h1F);
    q8.push_back(64'hFF);
    q8m.push_back(64'hFF);
    for (int i = 0; i < 15; i++) begin
      beat(1'b1, 1'b1);
      chk("w5 count", 64'(b5.o_count), 64'((i + 1) % 5));
    end
    beat(1'b0, 1'b0, 1'b1);
    repeat (2) beat(1'b0, 1'b0);
    chk("w8 words outstanding", 64'(q8.size()), 64'd0);
    chk("w8m words outstanding", 64'(q8m.size()), 64'd0);
    chk("w5 words outstanding", 64'(q5.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
